// File: rtl/alu_exec_unit_if.sv
// alu_exec_unit_if: operation request and register-bank write-back bundle for alu_exec_unit.
interface alu_exec_unit_if;
   logic        START;
   logic [2:0]  OP;
   logic [31:0] PRA;
   logic [31:0] PRB;
   logic [3:0]  WC_IN;
   logic        BUSY;
   logic        DONE;
   logic [31:0] WPC;
   logic [3:0]  WC;
   logic        WC_Activator;
   logic        ZERO;
   logic        CARRY;
   modport master (output START, OP, PRA, PRB, WC_IN,
                   input BUSY, DONE, WPC, WC, WC_Activator, ZERO, CARRY);
   modport slave  (input START, OP, PRA, PRB, WC_IN,
                   output BUSY, DONE, WPC, WC, WC_Activator, ZERO, CARRY);
endinterface

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: single-issue ALU with 1-cycle simple ops and 32-step iterative MUL/DIVU, registered write-back.
module alu_exec_unit (
   input logic         CLK,
   input logic         RESET,
   alu_exec_unit_if.slave bus
);
   typedef enum logic [1:0] {IDLE, EXEC, ITER, WB} state_t;
   state_t state, state_nxt;
   logic [2:0] op;
   logic [31:0] a, b, acc, simple, mul_acc, div_q, div_rem, res, wpc;
   logic [32:0] sum, rem_sh, diff;
   logic [3:0] wc, wc_o;
   logic [4:0] cnt;
   logic ge, cy, zero, carry;
   always_comb begin
      sum = {1'b0, a} + {1'b0, b};
      simple = op == 3'b000 ? sum[31:0] :
               op == 3'b001 ? a - b :
               op == 3'b010 ? a & b :
               op == 3'b011 ? a | b :
               op == 3'b100 ? a ^ b :
               op == 3'b101 ? a << b[4:0] : 32'h0;
      mul_acc = acc + (b[0] ? a : 32'h0);
      // restoring division: acc is the partial remainder, a shifts dividend out and quotient in
      rem_sh = {acc, a[31]};
      diff = rem_sh - {1'b0, b};
      ge = rem_sh >= {1'b0, b};
      div_rem = ge ? diff[31:0] : rem_sh[31:0];
      div_q = {a[30:0], ge};
      res = state == ITER ? (op[0] ? div_q : mul_acc) : simple;
      cy = state == ITER ? 1'b0 :
           op == 3'b000 ? sum[32] :
           op == 3'b001 ? a >= b : 1'b0;
   end
   always_comb begin
      state_nxt = state;
      state_nxt = state == IDLE ? (bus.START ? (&bus.OP[2:1] ? ITER : EXEC) : IDLE) :
                  state == EXEC ? WB :
                  state == ITER ? (cnt == 5'd31 ? WB : ITER) : IDLE;
   end
   always_ff @(posedge CLK or posedge RESET)
      if (RESET) state <= IDLE;
      else state <= state_nxt;
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         {op, a, b, acc, wc, cnt, wpc, wc_o, zero, carry} <= '0;
      end else begin
         if (state == IDLE && bus.START) begin
            op <= bus.OP;
            a <= bus.PRA;
            b <= bus.PRB;
            wc <= bus.WC_IN;
            acc <= 32'h0;
            cnt <= 5'd0;
         end
         if (state == ITER) begin
            cnt <= cnt + 5'd1;
            acc <= op[0] ? div_rem : mul_acc;
            a <= op[0] ? div_q : a << 1;
            b <= op[0] ? b : b >> 1;
         end
         if (state_nxt == WB) begin
            wpc <= res;
            zero <= res == 32'h0;
            carry <= cy;
            wc_o <= wc;
         end
      end
   end
   assign bus.BUSY = state != IDLE;
   assign bus.DONE = state == WB;
   assign bus.WC_Activator = state == WB;
   assign bus.WPC = wpc;
   assign bus.WC = wc_o;
   assign bus.ZERO = zero;
   assign bus.CARRY = carry;
endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 SHALL have port CLK  in  1  single clock; all state changes on rising edge.
REQ-002 SHALL have port RESET  in  1  asynchronous, active-high reset.
REQ-003 SHALL have port START  in  1  request to execute one operation; sampled only in IDLE.
REQ-004 SHALL have port OP  in  3  operation select (encoding in REQ-012).
REQ-005 SHALL have ports PRA, PRB  in  32 each  operand A and operand B, read from the register bank read ports.
REQ-006 SHALL have port WC_IN  in  4  destination register index travelling with the operation.
REQ-007 SHALL have port BUSY  out  1  high whenever state is not IDLE.
REQ-008 SHALL have port DONE  out  1  one-cycle pulse marking a valid result.
REQ-009 SHALL have ports WPC  out 32, WC  out 4, WC_Activator  out 1  write-back data, destination and write enable, fed straight into the register bank write port.
REQ-010 SHALL have ports ZERO, CARRY  out  1 each  result flags.

Function
REQ-011 SHALL implement FSM states IDLE, EXEC, ITER, WB.
REQ-012 SHALL decode OP:
- 000 ADD
- 001 SUB (A-B)
- 010 AND
- 011 OR
- 100 XOR
- 101 SLL (A << B[4:0])
- 110 MUL (unsigned, low 32 bits)
- 111 DIVU (unsigned quotient)
REQ-013 SHALL, on a rising edge in IDLE with START=1, capture PRA, PRB, OP and WC_IN into internal registers; later changes on these inputs have no effect on the operation.
REQ-014 SHALL, after that capture, go to EXEC for OP 000-101 and to ITER for OP 110-111.
REQ-015 SHALL, in EXEC, compute the result in one cycle and enter WB at the next edge.
REQ-016 SHALL, in ITER, run a 5-bit counter from 0 to 31, one shift-add (MUL) or one restoring shift-subtract (DIVU) step per cycle, and enter WB on the edge where the counter reaches 31.
REQ-017 SHALL give these latencies, with START sampled at edge N:
- simple ops: WB spans edges N+1 to N+2
- iterative ops: WB spans edges N+32 to N+33
REQ-018 SHALL, in WB, hold DONE=1 and WC_Activator=1 for exactly one cycle, with WPC and WC valid, and return to IDLE at the next edge.
REQ-019 SHALL hold WC_Activator=0 outside WB; WPC, WC and the flags keep their last values.
REQ-020 SHALL ignore START whenever state is not IDLE; no queuing.
REQ-021 SHALL accept a new START on the IDLE cycle directly after WB (back-to-back issue).
REQ-022 SHALL wrap ADD, SUB, MUL and SLL results modulo 2^32.
REQ-023 SHALL set CARRY from the operation:
- ADD: carry-out of bit 31
- SUB: 1 when A >= B unsigned (no borrow)
- all other ops: 0
REQ-024 SHALL set ZERO = (WPC == 0), updated in the same edge as WPC.
REQ-025 SHALL, for DIVU with B == 0, produce WPC = 32'hFFFFFFFF with the normal 32-cycle latency.

Reset
REQ-026 SHALL, when RESET=1, immediately and asynchronously force:
- state to IDLE
- counter to 0
- BUSY, DONE, WC_Activator, ZERO and CARRY to 0
- WPC to 32'h0 and WC to 4'h0
REQ-027 SHALL, on RESET asserted during EXEC, ITER or WB, abort the operation with no write pulse, and SHALL not pulse WC_Activator after RESET is released until a new START.
REQ-028 SHALL ignore START while RESET=1.

Verification
REQ-029 SHALL cover: ADD A=32'hFFFFFFFF, B=1, WC_IN=3 -> WB at N+1; WPC=0, ZERO=1, CARRY=1, WC=3, WC_Activator high for one cycle.
REQ-030 SHALL cover: SUB A=5, B=7 -> WPC=32'hFFFFFFFE, CARRY=0; then SLL A=1, B=32'h23 -> WPC=8 (shift uses B[4:0]=3).
REQ-031 SHALL cover: MUL A=32'h00010001, B=32'h00010001 -> BUSY for 33 cycles, DONE at edge N+32, WPC=32'h00020001; START pulses during ITER are ignored.
REQ-032 SHALL cover: DIVU A=100, B=7 -> WPC=14; DIVU A=9, B=0 -> WPC=32'hFFFFFFFF, ZERO=0.
REQ-033 SHALL cover: RESET asserted at ITER counter=10 -> all outputs 0 immediately, no DONE afterwards, and the next START (ADD 2+2) completes with WPC=4.
REQ-034 SHALL cover: back-to-back ADD then XOR (A=32'hF0F0F0F0, B=32'hFFFFFFFF) -> two single-cycle DONE pulses three cycles apart; second WPC=32'h0F0F0F0F.
